// File: rtl/motor_cmd_sequencer.sv
// Per-wheel speed sequencer: bounded-rate magnitude slewing with a zero-speed dead interval before reversals.
// Optional build macro MOTOR_SEQ_MIRROR_EN inverts the motor2_sign output for a mirror-mounted wheel.
module motor_cmd_sequencer #(
  parameter int TICK_DIV   = 1000,
  parameter int STEP       = 5,
  parameter int DEAD_TICKS = 2,
  parameter int MAX_MAG    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_m1,
  input  logic [7:0] cmd_m2,
  input  logic       estop,
  output logic       motor1_sign,
  output logic [6:0] motor1_upperlimit,
  output logic       motor2_sign,
  output logic [6:0] motor2_upperlimit,
  output logic       busy
);

`ifdef MOTOR_SEQ_MIRROR_EN
  localparam logic MIRROR = 1'b1;
`else
  localparam logic MIRROR = 1'b0;
`endif

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_TICKS);
  localparam logic [6:0]    STEP7     = 7'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, DEAD} state_t;

  logic [PW-1:0] presc;
  logic          tick;

  state_t        state_q [2];
  state_t        state_d [2];
  logic [6:0]    mag_q   [2];
  logic [6:0]    mag_d   [2];
  logic          sgn_q   [2];
  logic          sgn_d   [2];
  logic [6:0]    tmag_q  [2];
  logic [6:0]    tmag_d  [2];
  logic          tsgn_q  [2];
  logic          tsgn_d  [2];
  logic [DW-1:0] dcnt_q  [2];
  logic [DW-1:0] dcnt_d  [2];
  logic [7:0]    cmd     [2];
  logic          accept;
  logic          ready_d;
  logic          busy_d;

  // -128 has no positive 8-bit twin; its 8-bit magnitude reads as 128 and clamps like any other overrange value
  function automatic logic [6:0] clamp_mag(input logic [7:0] c);
    logic [7:0] a;
    a = c[7] ? (~c + 8'd1) : c;
    if (a > 8'(MAX_MAG)) return 7'(MAX_MAG);
    return a[6:0];
  endfunction

  assign tick   = (presc == TICK_LAST);
  assign cmd[0] = cmd_m1;
  assign cmd[1] = cmd_m2;
  assign accept = cmd_valid & cmd_ready & ~estop;

  // Next-state for both motors; ramp work happens only on tick and always against the old target
  always_comb begin
    logic [6:0] delta;
    logic [6:0] nmag;
    logic       differs;
    delta   = '0;
    nmag    = '0;
    differs = 1'b0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      mag_d[i]   = mag_q[i];
      sgn_d[i]   = sgn_q[i];
      tmag_d[i]  = tmag_q[i];
      tsgn_d[i]  = tsgn_q[i];
      dcnt_d[i]  = dcnt_q[i];
      differs    = (tmag_q[i] != mag_q[i]) ||
                   ((tmag_q[i] != 7'd0) && (tsgn_q[i] != sgn_q[i]));

      case (state_q[i])
        IDLE, RAMP: begin
          if (tick && (state_q[i] == RAMP || differs)) begin
            if (tsgn_q[i] == sgn_q[i] || tmag_q[i] == 7'd0) begin
              if (mag_q[i] < tmag_q[i]) begin
                delta = tmag_q[i] - mag_q[i];
                if (delta > STEP7) delta = STEP7;
                nmag = mag_q[i] + delta;
              end else begin
                delta = mag_q[i] - tmag_q[i];
                if (delta > STEP7) delta = STEP7;
                nmag = mag_q[i] - delta;
              end
              mag_d[i]   = nmag;
              state_d[i] = (nmag == tmag_q[i]) ? IDLE : RAMP;
            end else begin
              // Reversal: bleed off magnitude first, sign only moves once we sit at zero
              delta = (mag_q[i] > STEP7) ? STEP7 : mag_q[i];
              nmag  = mag_q[i] - delta;
              mag_d[i] = nmag;
              if (nmag == 7'd0) begin
                state_d[i] = DEAD;
                dcnt_d[i]  = DEAD_INIT;
              end else begin
                state_d[i] = RAMP;
              end
            end
          end else if (state_q[i] == IDLE && differs) begin
            state_d[i] = RAMP;
          end
        end
        DEAD: begin
          if (tick) begin
            if (tsgn_q[i] == sgn_q[i]) begin
              dcnt_d[i]  = '0;
              state_d[i] = (tmag_q[i] == 7'd0) ? IDLE : RAMP;
            end else if (dcnt_q[i] <= DW'(1)) begin
              dcnt_d[i]  = '0;
              sgn_d[i]   = tsgn_q[i];
              state_d[i] = (tmag_q[i] == 7'd0) ? IDLE : RAMP;
            end else begin
              dcnt_d[i] = dcnt_q[i] - DW'(1);
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase

      if (accept) begin
        tmag_d[i] = clamp_mag(cmd[i]);
        tsgn_d[i] = (cmd[i] == 8'd0) ? sgn_q[i] : ~cmd[i][7];
      end

      if (estop) begin
        state_d[i] = IDLE;
        mag_d[i]   = '0;
        sgn_d[i]   = sgn_q[i];
        tmag_d[i]  = '0;
        tsgn_d[i]  = sgn_q[i];
        dcnt_d[i]  = '0;
      end
    end
    ready_d = ~estop & (state_d[0] != DEAD) & (state_d[1] != DEAD);
    busy_d  = (state_d[0] != IDLE) | (state_d[1] != IDLE);
  end

  // State and output registers; outputs are loaded from next-state so every port is a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      presc       <= '0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      motor2_sign <= ~MIRROR;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        mag_q[i]   <= '0;
        sgn_q[i]   <= 1'b1;
        tmag_q[i]  <= '0;
        tsgn_q[i]  <= 1'b1;
        dcnt_q[i]  <= '0;
      end
    end else begin
      presc       <= tick ? '0 : presc + PW'(1);
      cmd_ready   <= ready_d;
      busy        <= busy_d;
      motor2_sign <= sgn_d[1] ^ MIRROR;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        mag_q[i]   <= mag_d[i];
        sgn_q[i]   <= sgn_d[i];
        tmag_q[i]  <= tmag_d[i];
        tsgn_q[i]  <= tsgn_d[i];
        dcnt_q[i]  <= dcnt_d[i];
      end
    end
  end

  assign motor1_sign       = sgn_q[0];
  assign motor1_upperlimit = mag_q[0];
  assign motor2_upperlimit = mag_q[1];

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed self-checking bench for motor_cmd_sequencer with a 4-cycle ramp tick.
module tb_motor_cmd_sequencer;

`ifdef MOTOR_SEQ_MIRROR_EN
  localparam logic MIRROR = 1'b1;
`else
  localparam logic MIRROR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_m1 = 8'd0;
  logic [7:0] cmd_m2 = 8'd0;
  logic       estop = 1'b0;
  logic       motor1_sign;
  logic [6:0] motor1_upperlimit;
  logic       motor2_sign;
  logic [6:0] motor2_upperlimit;
  logic       busy;

  int total = 0;
  int bad = 0;
  int ph = 0;

  motor_cmd_sequencer #(
    .TICK_DIV(4), .STEP(5), .DEAD_TICKS(2), .MAX_MAG(100)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m1(cmd_m1), .cmd_m2(cmd_m2), .estop(estop),
    .motor1_sign(motor1_sign), .motor1_upperlimit(motor1_upperlimit),
    .motor2_sign(motor2_sign), .motor2_upperlimit(motor2_upperlimit),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase: 3 marks the cycle whose closing edge applies a ramp step
  always @(posedge clk) begin
    if (reset) ph <= 0;
    else ph <= (ph == 3) ? 0 : ph + 1;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit expired, required bench completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    while (ph != 3) step();
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic send(input int m1, input int m2);
    cmd_valid = 1'b1;
    cmd_m1 = 8'(m1);
    cmd_m2 = 8'(m2);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", cmd_ready); end
      total++;
      if ({motor1_sign, motor2_sign} !== {1'b1, ~MIRROR}) begin
        bad++; $display("[TB] FAIL reset_signs got=%b%b want=%b%b", motor1_sign, motor2_sign, 1'b1, ~MIRROR);
      end
      total++;
      if ({motor1_upperlimit, motor2_upperlimit, busy} !== 15'd0) begin
        bad++; $display("[TB] FAIL reset_limits got=%0d/%0d busy=%b want=0/0 busy=0", motor1_upperlimit, motor2_upperlimit, busy);
      end
    end
    reset = 1'b0;
    step();
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_ramp_up();
    int e1;
    send(30, 100);
    for (int k = 1; k <= 20; k++) begin
      wait_tick();
      e1 = (5 * k < 30) ? 5 * k : 30;
      total++;
      if (motor1_upperlimit !== 7'(e1)) begin bad++; $display("[TB] FAIL ramp_m1 tick=%0d got=%0d want=%0d", k, motor1_upperlimit, e1); end
      total++;
      if (motor2_upperlimit !== 7'(5 * k)) begin bad++; $display("[TB] FAIL ramp_m2 tick=%0d got=%0d want=%0d", k, motor2_upperlimit, 5 * k); end
      total++;
      if (busy !== (k < 20)) begin bad++; $display("[TB] FAIL ramp_busy tick=%0d got=%b want=%b", k, busy, (k < 20)); end
    end
  endtask

  task automatic test_reversal();
    int  emag [7] = '{5, 0, 0, 0, 5, 10, 12};
    logic esgn [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic erdy [7] = '{1, 0, 0, 1, 1, 1, 1};
    send(10, 100);
    for (int k = 0; k < 4; k++) wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd10) begin bad++; $display("[TB] FAIL rev_setup got=%0d want=10", motor1_upperlimit); end
    send(-12, 100);
    for (int k = 0; k < 7; k++) begin
      wait_tick();
      total++;
      if (motor1_upperlimit !== 7'(emag[k]) || motor1_sign !== esgn[k] || cmd_ready !== erdy[k]) begin
        bad++;
        $display("[TB] FAIL rev_seq tick=%0d got mag=%0d sign=%b rdy=%b want mag=%0d sign=%b rdy=%b",
                 k + 1, motor1_upperlimit, motor1_sign, cmd_ready, emag[k], esgn[k], erdy[k]);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rev_busy got=%b want=0", busy); end
  endtask

  task automatic test_clamp();
    int e;
    send(-128, 100);
    for (int k = 1; k <= 20; k++) begin
      wait_tick();
      e = (12 + 5 * k < 100) ? 12 + 5 * k : 100;
      total++;
      if (motor1_upperlimit !== 7'(e) || motor1_sign !== 1'b0) begin
        bad++; $display("[TB] FAIL clamp tick=%0d got mag=%0d sign=%b want mag=%0d sign=0", k, motor1_upperlimit, motor1_sign, e);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    send(10, 0);
    wait_tick();
    wait_tick();
    send(-5, 0);
    wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd5) begin bad++; $display("[TB] FAIL abort_down got=%0d want=5", motor1_upperlimit); end
    while (ph != 3) step();
    send(7, 0);
    total++;
    if (motor1_upperlimit !== 7'd0 || cmd_ready !== 1'b0 || motor1_sign !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_dead got mag=%0d rdy=%b sign=%b want 0/0/1", motor1_upperlimit, cmd_ready, motor1_sign);
    end
    wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd0 || cmd_ready !== 1'b1 || motor1_sign !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_exit got mag=%0d rdy=%b sign=%b want 0/1/1", motor1_upperlimit, cmd_ready, motor1_sign);
    end
    wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd5) begin bad++; $display("[TB] FAIL abort_ramp1 got=%0d want=5", motor1_upperlimit); end
    wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd7 || motor1_sign !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_final got mag=%0d sign=%b busy=%b want 7/1/0", motor1_upperlimit, motor1_sign, busy);
    end
  endtask

  task automatic test_estop();
    do_reset();
    send(60, 20);
    for (int k = 0; k < 8; k++) wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd40 || motor2_upperlimit !== 7'd20) begin
      bad++; $display("[TB] FAIL estop_setup got=%0d/%0d want=40/20", motor1_upperlimit, motor2_upperlimit);
    end
    total++;
    if (motor2_sign !== ~MIRROR) begin bad++; $display("[TB] FAIL mirror_sign got=%b want=%b", motor2_sign, ~MIRROR); end
    estop = 1'b1;
    send(-50, -50);
    total++;
    if (motor1_upperlimit !== 7'd0 || motor2_upperlimit !== 7'd0 || cmd_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL estop_hit got=%0d/%0d rdy=%b busy=%b want 0/0 rdy=0 busy=0",
                      motor1_upperlimit, motor2_upperlimit, cmd_ready, busy);
    end
    total++;
    if (motor1_sign !== 1'b1 || motor2_sign !== ~MIRROR) begin
      bad++; $display("[TB] FAIL estop_signs got=%b%b want=1%b", motor1_sign, motor2_sign, ~MIRROR);
    end
    for (int c = 0; c < 5; c++) step();
    estop = 1'b0;
    step();
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL estop_release_rdy got=%b want=1", cmd_ready); end
    for (int k = 0; k < 3; k++) wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd0 || motor2_upperlimit !== 7'd0 || motor1_sign !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL estop_hold got=%0d/%0d sign=%b busy=%b want 0/0 sign=1 busy=0",
                      motor1_upperlimit, motor2_upperlimit, motor1_sign, busy);
    end
    send(15, 0);
    wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd5 || motor1_sign !== 1'b1) begin
      bad++; $display("[TB] FAIL estop_resume got mag=%0d sign=%b want 5/1", motor1_upperlimit, motor1_sign);
    end
  endtask

  task automatic test_reset_mid_dead();
    send(10, 0);
    wait_tick();
    wait_tick();
    send(-10, 0);
    wait_tick();
    wait_tick();
    total++;
    if (cmd_ready !== 1'b0 || motor1_upperlimit !== 7'd0) begin
      bad++; $display("[TB] FAIL middead_setup got rdy=%b mag=%0d want 0/0", cmd_ready, motor1_upperlimit);
    end
    step();
    reset = 1'b1;
    step();
    total++;
    if ({motor1_sign, motor2_sign, motor1_upperlimit, motor2_upperlimit, cmd_ready, busy} !== {1'b1, ~MIRROR, 16'd0}) begin
      bad++; $display("[TB] FAIL middead_reset got s=%b%b lim=%0d/%0d rdy=%b busy=%b want s=1%b lim=0/0 rdy=0 busy=0",
                      motor1_sign, motor2_sign, motor1_upperlimit, motor2_upperlimit, cmd_ready, busy, ~MIRROR);
    end
    reset = 1'b0;
    step();
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL middead_ready got=%b want=1", cmd_ready); end
    for (int k = 0; k < 3; k++) wait_tick();
    total++;
    if (motor1_upperlimit !== 7'd0 || motor1_sign !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL middead_quiet got mag=%0d sign=%b busy=%b want 0/1/0", motor1_upperlimit, motor1_sign, busy);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_clamp();
    test_abort();
    test_estop();
    test_reset_mid_dead();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sequencer.md
# motor_cmd_sequencer

Sequences speed commands into the `motor_controller` PWM datapath for both wheels of the balance robot. It accepts signed per-motor speed targets from the balance loop over a valid/ready handshake. It slews each motor's magnitude toward its target at a bounded rate and enforces a zero-speed dead interval before any direction reversal. It drives `motor1_sign`/`motor1_upperlimit`/`motor2_sign`/`motor2_upperlimit` directly.

## Interface
- `TICK_DIV`, 1000: `clk` cycles per ramp tick (≥2).
- `STEP`, 5: maximum magnitude change per tick, per motor (1..127).
- `DEAD_TICKS`, 2: ticks held at zero before a sign flip (≥1).
- `MAX_MAG`, 100: magnitude clamp (≤127).

- `clk` in 1: motor-domain clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer accepts command.
- `cmd_m1` in 8: motor 1 target, two's complement.
- `cmd_m2` in 8: motor 2 target, two's complement.
- `estop` in 1: emergency stop, level-sensitive.
- `motor1_sign` out 1: 1 = forward (positive command).
- `motor1_upperlimit` out 7: motor 1 duty magnitude.
- `motor2_sign` out 1: motor 2 direction.
- `motor2_upperlimit` out 7: motor 2 duty magnitude.
- `busy` out 1: either motor not at target.

## Operation
- Accept occurs when `cmd_valid & cmd_ready` at a rising edge. Both targets are latched, and the latest command wins.
- Target magnitude is `min(|cmd|, MAX_MAG)`; -128 maps to `MAX_MAG`. Target sign is 1 for cmd>0 and 0 for cmd<0. For cmd=0 the target sign equals the current sign.
- The prescaler counts 0..`TICK_DIV`-1 and pulses `tick` at `TICK_DIV`-1, then wraps. Ramping acts only on `tick`.
- Each motor has an independent FSM with states IDLE, RAMP and DEAD:
  - **IDLE**: current equals target. A differing target moves the FSM to RAMP, evaluated on the next tick.
  - **RAMP, same sign**: magnitude moves toward target by `min(STEP, |diff|)`. Reaching the target moves the FSM to IDLE.
  - **RAMP, opposite sign**: magnitude decreases by `min(STEP, mag)`. When magnitude hits 0 the FSM moves to DEAD and loads `dead_cnt=DEAD_TICKS`.
  - **DEAD**: magnitude stays 0 and `dead_cnt` decrements per tick. At 0, sign flips to target sign and the FSM moves to RAMP (or IDLE if target magnitude is 0).
  - **DEAD, new target with same sign as current**: the dead interval is aborted on the next tick and the FSM moves to RAMP/IDLE. An opposite-sign retarget does not restart `dead_cnt`.
- Sign never changes while magnitude ≠ 0.
- `cmd_ready` = !reset_q & !estop & neither FSM in DEAD.
- `busy` = either FSM ≠ IDLE.
- `estop` high:
  - Both magnitudes go to 0 and both targets are cleared to 0.
  - FSMs return to IDLE and `dead_cnt` clears.
  - Signs are held and `cmd_ready` is 0.
  - After release, outputs stay 0 until a new command is accepted.
- `estop` beats an accept in the same cycle; the command is dropped.

## Timing
- All outputs are registered.
- Reset values: `motor*_sign`=1, `motor*_upperlimit`=0, `cmd_ready`=0, `busy`=0. The prescaler, `dead_cnt` and targets are 0, and the FSMs are IDLE.
- `cmd_ready` rises on the first edge after `reset` deasserts.
- Accept at edge N updates `busy` at N+1. The first magnitude change appears on the edge ending the first `tick` cycle after N.
- A `tick` in the same cycle as an accept uses the old target.
- The prescaler free-runs and is not resynchronised by commands.
- `estop` asserted in cycle C gives zero outputs and `cmd_ready`=0 from edge C+1.
- `reset` mid-operation behaves exactly as power-on reset at the next edge, including mid-DEAD and mid-ramp.

## Configuration
- `MOTOR_SEQ_MIRROR_EN` defined: the `motor2_sign` output is the inverse of motor 2's internal sign, for mirror-mounted wheels. The reset value of `motor2_sign` becomes 0. `cmd_m2` semantics are unchanged.
- Not defined: `motor2_sign` equals motor 2's internal sign.

## Test plan
Bench parameters: TICK_DIV=4, STEP=5, DEAD_TICKS=2, MAX_MAG=100.
- **Reset**: hold `reset` 3 cycles, then release → signs=1, limits=0, `busy`=0; `cmd_ready`=0 during reset and 1 one edge after release.
- **Ramp up**: m1=+30, m2=+100 → m1 steps 5,10,…,30 over 6 ticks (24 cycles). m2 reaches 100 after 20 ticks. `busy` falls after m2 settles.
- **Reversal**: m1 at +10, command -12 → sequence 5, 0, then 2 ticks at 0 with `cmd_ready`=0, then sign→0, then 5, 10, 12.
- **Clamp and abort**:
  - cmd -128 → magnitude ramps to exactly 100 and never exceeds it.
  - +10→-5 then +7 during DEAD → DEAD aborted, sign stays 1, magnitude ramps to 7.
- **Estop**: estop at m1=40 mid-ramp → limits 0 at the next edge, `cmd_ready`=0, signs held. After release, limits stay 0 until a new accept; a command driven simultaneously with estop is dropped.
- **Mirror and reset**: with `MOTOR_SEQ_MIRROR_EN` and m2=+20, `motor2_sign`=0. Reset asserted mid-DEAD → all reset values at the next edge.
